// File: rtl/gameplay_input_ctrl.sv
// Control-input front end for the gameplay core: synchronizes and debounces the buttons
// and vsync, then turns them into new_game/new_frame pulses, pan levels and a gated hit charge.
module gameplay_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter logic [2:0]  STATE_RESTING   = 3'd0,
   parameter logic [2:0]  STATE_CHARGING  = 3'd1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       btn_hit,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_new,
   input  logic       vsync_in,
   input  logic [2:0] state_in,
   output logic       new_game,
   output logic       charging_hit,
   output logic       camera_pan_left,
   output logic       camera_pan_right,
   output logic       new_frame,
   output logic [1:0] dbg_hit_state
);

   localparam logic [1:0] HIT_DISARMED = 2'd0;
   localparam logic [1:0] HIT_ARMED    = 2'd1;
   localparam logic [1:0] HIT_CHARGING = 2'd2;

   localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

   localparam int B_HIT   = 0;
   localparam int B_LEFT  = 1;
   localparam int B_RIGHT = 2;
   localparam int B_NEW   = 3;

   logic [3:0]  raw_btn;
   logic [3:0]  btn_s1;
   logic [3:0]  btn_s2;
   logic [3:0]  btn_db;
   logic [31:0] db_cnt [4];

   logic        vs_s1;
   logic        vs_s2;
   logic        vs_s2_d;

   logic        new_db_d;
   logic        new_game_next;

   logic        hit_primed;
   logic        hit_quiet;
   logic [1:0]  hit_state;
   logic [1:0]  hit_next;
   logic        state_resting;
   logic        state_charging;

   assign raw_btn = {btn_new, btn_right, btn_left, btn_hit};

   // Two-flop synchronizers for every asynchronous input.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         btn_s1 <= 4'b0;
         btn_s2 <= 4'b0;
         vs_s1  <= 1'b0;
         vs_s2  <= 1'b0;
      end else begin
         btn_s1 <= raw_btn;
         btn_s2 <= btn_s1;
         vs_s1  <= vsync_in;
         vs_s2  <= vs_s1;
      end
   end

   // Per-button debounce: the value flips only after DEBOUNCE_CYCLES consecutive disagreements.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         btn_db <= 4'b0;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (btn_s2[i] == btn_db[i]) begin
               db_cnt[i] <= 32'd0;
            end else if (db_cnt[i] == DB_LAST) begin
               btn_db[i] <= btn_s2[i];
               db_cnt[i] <= 32'd0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         vs_s2_d   <= 1'b0;
         new_frame <= 1'b0;
      end else begin
         vs_s2_d   <= vs_s2;
         new_frame <= vs_s2 & ~vs_s2_d;
      end
   end

   assign new_game_next = btn_db[B_NEW] & ~new_db_d;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         new_db_d         <= 1'b0;
         new_game         <= 1'b0;
         camera_pan_left  <= 1'b0;
         camera_pan_right <= 1'b0;
      end else begin
         new_db_d         <= btn_db[B_NEW];
         new_game         <= new_game_next;
         camera_pan_left  <= btn_db[B_LEFT] & ~btn_db[B_RIGHT];
         camera_pan_right <= btn_db[B_RIGHT] & ~btn_db[B_LEFT];
      end
   end

   // Arming needs a hit input that reads released all the way through the synchronizer;
   // hit_primed blocks the first cycle after reset, when the sync flops still hold reset zeros.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hit_primed <= 1'b0;
      end else begin
         hit_primed <= 1'b1;
      end
   end

   assign hit_quiet      = hit_primed & ~btn_s1[B_HIT] & ~btn_s2[B_HIT] & ~btn_db[B_HIT];
   assign state_resting  = (state_in == STATE_RESTING);
   assign state_charging = (state_in == STATE_CHARGING);

   always_comb begin
      hit_next = hit_state;
      case (hit_state)
         HIT_DISARMED: begin
            if (hit_quiet && state_resting) begin
               hit_next = HIT_ARMED;
            end
         end
         HIT_ARMED: begin
            if (!state_resting) begin
               hit_next = HIT_DISARMED;
            end else if (btn_db[B_HIT]) begin
               hit_next = HIT_CHARGING;
            end
         end
         HIT_CHARGING: begin
            if (!state_resting && !state_charging) begin
               hit_next = HIT_DISARMED;
            end else if (!btn_db[B_HIT]) begin
               hit_next = HIT_DISARMED;
            end
         end
         default: begin
            hit_next = HIT_DISARMED;
         end
      endcase
   end

   // A new_game pulse overrides whatever the FSM would do in the same cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hit_state    <= HIT_DISARMED;
         charging_hit <= 1'b0;
      end else if (new_game_next) begin
         hit_state    <= HIT_DISARMED;
         charging_hit <= 1'b0;
      end else begin
         hit_state    <= hit_next;
         charging_hit <= (hit_next == HIT_CHARGING);
      end
   end

   assign dbg_hit_state = hit_state;

endmodule

// File: tb/tb_gameplay_input_ctrl.sv
// Directed bench for gameplay_input_ctrl with DEBOUNCE_CYCLES=4: debounce, hit FSM gating,
// vsync pulses, pan exclusivity and new_game override.
module tb_gameplay_input_ctrl;

   localparam logic [1:0] ST_DISARMED = 2'd0;
   localparam logic [1:0] ST_ARMED    = 2'd1;

   logic       clk_in;
   logic       rst_in;
   logic       btn_hit;
   logic       btn_left;
   logic       btn_right;
   logic       btn_new;
   logic       vsync_in;
   logic [2:0] state_in;
   logic       new_game;
   logic       charging_hit;
   logic       camera_pan_left;
   logic       camera_pan_right;
   logic       new_frame;
   logic [1:0] dbg_hit_state;

   int n_checks;
   int n_fail;
   int cyc;
   int nf_pulses;
   logic [31:0] exp_q[$];

   gameplay_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .STATE_RESTING(3'd0),
      .STATE_CHARGING(3'd1)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .btn_hit(btn_hit),
      .btn_left(btn_left),
      .btn_right(btn_right),
      .btn_new(btn_new),
      .vsync_in(vsync_in),
      .state_in(state_in),
      .new_game(new_game),
      .charging_hit(charging_hit),
      .camera_pan_left(camera_pan_left),
      .camera_pan_right(camera_pan_right),
      .new_frame(new_frame),
      .dbg_hit_state(dbg_hit_state)
   );

   // Clock and cycle counter
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance n edges, then settle 1 time unit past the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic apply_reset(input int n);
      rst_in = 1'b1;
      step(n);
      rst_in = 1'b0;
   endtask

   // Watches new_frame after each step and matches pulses against the expected queue
   task automatic step_nf(input int n);
      for (int i = 0; i < n; i++) begin
         step(1);
         if (new_frame) begin
            nf_pulses++;
            if (exp_q.size() > 0) check("nf_time", cyc, exp_q.pop_front());
            else check("nf_extra", 1, 0);
         end
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      nf_pulses = 0;
      btn_hit   = 1'b0;
      btn_left  = 1'b0;
      btn_right = 1'b0;
      btn_new   = 1'b0;
      vsync_in  = 1'b0;
      state_in  = 3'd0;

      // Reset state
      apply_reset(3);
      check("rst_new_game", new_game, 0);
      check("rst_charging", charging_hit, 0);
      check("rst_pan_l", camera_pan_left, 0);
      check("rst_pan_r", camera_pan_right, 0);
      check("rst_new_frame", new_frame, 0);
      check("rst_state", dbg_hit_state, ST_DISARMED);

      // 1. One-cycle glitches every 3 cycles never pass the debouncer
      for (int i = 0; i < 30; i++) begin
         btn_hit = (i % 3 == 0);
         step(1);
         check("glitch_charging", charging_hit, 0);
         check("glitch_db", dut.btn_db[0], 0);
      end
      btn_hit = 1'b0;

      // 2. Held from reset: no auto-fire; release, wait, press -> charge after 7 edges
      btn_hit = 1'b1;
      apply_reset(2);
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("held_charging", charging_hit, 0);
      end
      check("held_state", dbg_hit_state, ST_DISARMED);
      btn_hit = 1'b0;
      step(8);
      check("armed_after_release", dbg_hit_state, ST_ARMED);
      btn_hit = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         check("press_latency", charging_hit, (k == 7) ? 1 : 0);
      end

      // 3. Gameplay moves to CHARGING; release drops charge 7 edges later
      state_in = 3'd1;
      step(3);
      check("charging_in_st1", charging_hit, 1);
      btn_hit = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         check("release_latency", charging_hit, (k < 7) ? 1 : 0);
      end
      state_in = 3'd2;
      step(10);
      check("st2_state", dbg_hit_state, ST_DISARMED);
      state_in = 3'd3;
      btn_hit  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1);
         check("st3_press", charging_hit, 0);
      end
      btn_hit  = 1'b0;
      state_in = 3'd0;
      step(10);
      check("rearm_resting", dbg_hit_state, ST_ARMED);

      // 5. Pans: both held -> both 0; release right -> left after debounce
      btn_left  = 1'b1;
      btn_right = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1);
         check("both_pan_l", camera_pan_left, 0);
         check("both_pan_r", camera_pan_right, 0);
      end
      btn_right = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         check("left_latency", camera_pan_left, (k == 7) ? 1 : 0);
         check("left_excl_r", camera_pan_right, 0);
      end
      btn_left  = 1'b0;
      btn_right = 1'b1;
      step(7);
      check("right_only_r", camera_pan_right, 1);
      check("right_only_l", camera_pan_left, 0);
      btn_right = 1'b0;
      step(8);
      check("pans_idle_r", camera_pan_right, 0);

      // 4. Two long vsync pulses -> exactly two new_frame pulses, 3 edges after each rise
      for (int b = 0; b < 2; b++) begin
         vsync_in = 1'b1;
         exp_q.push_back(32'(cyc + 3));
         step_nf(100);
         vsync_in = 1'b0;
         step_nf(20);
      end
      check("nf_count", nf_pulses, 2);
      check("nf_queue_empty", exp_q.size(), 0);

      // 6. new_game while charging: one pulse, charge drops same cycle, re-arm needs release
      check("pre6_state", dbg_hit_state, ST_ARMED);
      btn_hit = 1'b1;
      step(7);
      check("pre6_charging", charging_hit, 1);
      btn_new = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         check("ng_pulse", new_game, (k == 7) ? 1 : 0);
         check("ng_charging", charging_hit, (k == 7) ? 0 : 1);
      end
      step(1);
      check("ng_width", new_game, 0);
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("ng_held", new_game, 0);
         check("ng_no_refire", charging_hit, 0);
      end
      check("ng_disarmed", dbg_hit_state, ST_DISARMED);
      btn_hit = 1'b0;
      step(8);
      check("ng_rearm", dbg_hit_state, ST_ARMED);
      btn_hit = 1'b1;
      step(7);
      check("ng_recharge", charging_hit, 1);

      // Reset mid-charge drops charging_hit on the next edge
      rst_in = 1'b1;
      step(1);
      check("rst_mid_charge", charging_hit, 0);
      rst_in = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
